// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_pkg
// Description : Shared defaults and types for the integer register file and
//               its write scoreboard.
//               Contents: default widths, the hard-wired zero register index,
//               and register index / data typedefs.
// Revision    : 1.0  initial release
// ============================================================================
package rf_pkg;

  localparam int DEFAULT_ADDRESS_WIDTH = 5;
  localparam int DEFAULT_DATA_WIDTH    = 32;

  // x0 reads as zero, ignores writes and is never marked pending
  localparam int ZERO_REG = 0;

  typedef logic [DEFAULT_ADDRESS_WIDTH-1:0] reg_idx_t;
  typedef logic [DEFAULT_DATA_WIDTH-1:0]    reg_data_t;

endpackage : rf_pkg
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : rf_scoreboard
// Description : Per-register pending (in-flight) bits with flush/set/clear
//               priority, plus a registered population count of the set bits.
// Ports       : clk, rst          - clock, async active-high reset
//               iss_en, iss_addr  - mark a destination register in flight
//               flush             - squash every in-flight mark
//               wr_en/wr_addr/wr_clr - writeback ports; wr_clr retires entry
//               pending           - current pending vector (bit 0 always 0)
//               pending_cnt       - registered count of pending bits
// Revision    : 1.0  initial release
// ============================================================================
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int NUM_WRITE     = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           iss_en,
  input  logic [ADDRESS_WIDTH-1:0]       iss_addr,
  input  logic                           flush,
  input  logic [NUM_WRITE-1:0]           wr_en,
  input  logic [NUM_WRITE*ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [NUM_WRITE-1:0]           wr_clr,
  output logic [2**ADDRESS_WIDTH-1:0]    pending,
  output logic [ADDRESS_WIDTH-1:0]       pending_cnt
);

  localparam int NREGS = 2**ADDRESS_WIDTH;

  logic [NREGS-1:0]         pending_q, pending_d;
  logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    pending_d = pending_q;
    // Retiring writes first, so a same-cycle issue (new producer) overrides
    for (int j = 0; j < NUM_WRITE; j++) begin
      if (wr_en[j] && wr_clr[j]) begin
        pending_d[wr_addr[j*ADDRESS_WIDTH +: ADDRESS_WIDTH]] = 1'b0;
      end
    end
    if (iss_en) begin
      pending_d[iss_addr] = 1'b1;
    end
    pending_d[ZERO_REG] = 1'b0;
    // Flush squashes everything, including an instruction issued this cycle
    if (flush) begin
      pending_d = '0;
    end

    // Count of the next state so the count lines up with the pending bits
    cnt_d = '0;
    for (int r = 1; r < NREGS; r++) begin
      cnt_d = cnt_d + ADDRESS_WIDTH'(pending_d[r]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pending     = pending_q;
  assign pending_cnt = cnt_q;

endmodule : rf_scoreboard
`default_nettype wire

// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_sb
// Description : Multi-port integer register file with same-cycle write-to-read
//               bypass and an integrated write scoreboard (rf_scoreboard).
// Ports       : clk, rst               - clock, async active-high reset
//               rd_addr/rd_data/rd_ready - packed combinational read ports
//               wr_en/wr_addr/wr_data/wr_clr - packed writeback ports
//               iss_en/iss_addr        - issue: mark destination in flight
//               flush                  - squash all in-flight marks
//               a0                     - registered value of reg A0_INDEX
//               pending_cnt            - number of in-flight registers
// Revision    : 1.0  initial release
// ============================================================================
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int NUM_READ      = 2,
  parameter int NUM_WRITE     = 2,
  parameter int A0_INDEX      = 10
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_READ*ADDRESS_WIDTH-1:0]  rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0]     rd_data,
  output logic [NUM_READ-1:0]                rd_ready,
  input  logic [NUM_WRITE-1:0]               wr_en,
  input  logic [NUM_WRITE*ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0]    wr_data,
  input  logic [NUM_WRITE-1:0]               wr_clr,
  input  logic                               iss_en,
  input  logic [ADDRESS_WIDTH-1:0]           iss_addr,
  input  logic                               flush,
  output logic [DATA_WIDTH-1:0]              a0,
  output logic [ADDRESS_WIDTH-1:0]           pending_cnt
);

  localparam int NREGS = 2**ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] X0 = ADDRESS_WIDTH'(ZERO_REG);

  logic [DATA_WIDTH-1:0] regs_q [NREGS];
  logic [DATA_WIDTH-1:0] regs_d [NREGS];
  logic [NREGS-1:0]      w_pending;

  // Ascending port order: the highest-indexed port wins on address collisions
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      regs_d[r] = regs_q[r];
    end
    for (int j = 0; j < NUM_WRITE; j++) begin
      if (wr_en[j] && (wr_addr[j*ADDRESS_WIDTH +: ADDRESS_WIDTH] != X0)) begin
        regs_d[wr_addr[j*ADDRESS_WIDTH +: ADDRESS_WIDTH]] = wr_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Entry 0 is never written, so it stays at its reset value of zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
    end
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_read
    logic [ADDRESS_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0]    w_data;
    logic                     w_ready;

    assign w_addr = rd_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];

    // A matching writeback supplies the operand this cycle, so it is ready
    // regardless of the pending bit
    always_comb begin
      w_data  = regs_q[w_addr];
      w_ready = ~w_pending[w_addr];
      for (int j = 0; j < NUM_WRITE; j++) begin
        if (wr_en[j] && (w_addr != X0) &&
            (wr_addr[j*ADDRESS_WIDTH +: ADDRESS_WIDTH] == w_addr)) begin
          w_data  = wr_data[j*DATA_WIDTH +: DATA_WIDTH];
          w_ready = 1'b1;
        end
      end
    end

    assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = w_data;
    assign rd_ready[i]                         = w_ready;
  end

  rf_scoreboard #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .NUM_WRITE     (NUM_WRITE)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .iss_en      (iss_en),
    .iss_addr    (iss_addr),
    .flush       (flush),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_clr      (wr_clr),
    .pending     (w_pending),
    .pending_cnt (pending_cnt)
  );

  // Straight from storage: a0 shows a write only after the clock edge
  assign a0 = regs_q[A0_INDEX];

endmodule : reg_file_sb
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_sb
// Description : Self-checking bench for reg_file_sb. Expected values are
//               queued as stimulus is applied and paired with DUT outputs at
//               the sample point; each scenario task compares its own pairs.
// Revision    : 1.0  initial release
// ============================================================================
module tb_reg_file_sb;

  localparam int K_DATA = 0;
  localparam int K_RDY  = 1;
  localparam int K_CNT  = 2;
  localparam int K_A0   = 3;

  typedef struct {
    int          kind;
    int          port;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic [1:0]  rd_ready;
  logic [1:0]  wr_en = '0;
  logic [9:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic [1:0]  wr_clr = '0;
  logic        iss_en = 1'b0;
  logic [4:0]  iss_addr = '0;
  logic        flush = 1'b0;
  logic [31:0] a0;
  logic [4:0]  pending_cnt;

  exp_t        exp_q[$];
  exp_t        cmp_q[$];
  logic [31:0] got_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] model [32];

  always #5 clk = ~clk;

  reg_file_sb dut (
    .clk         (clk),
    .rst         (rst),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_ready    (rd_ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_clr      (wr_clr),
    .iss_en      (iss_en),
    .iss_addr    (iss_addr),
    .flush       (flush),
    .a0          (a0),
    .pending_cnt (pending_cnt)
  );

  function automatic string kname(input int k);
    case (k)
      K_DATA:  return "rd_data";
      K_RDY:   return "rd_ready";
      K_CNT:   return "pending_cnt";
      default: return "a0";
    endcase
  endfunction

  function automatic logic [31:0] observe(input int k, input int p);
    case (k)
      K_DATA:  return rd_data[p*32 +: 32];
      K_RDY:   return {31'b0, rd_ready[p]};
      K_CNT:   return {27'b0, pending_cnt};
      default: return a0;
    endcase
  endfunction

  task automatic expect_v(input int k, input int p, input logic [31:0] v);
    exp_t e;
    e.kind = k; e.port = p; e.val = v;
    exp_q.push_back(e);
  endtask

  // Pairs every queued expectation with what the DUT shows right now
  task automatic capture();
    exp_t e;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      cmp_q.push_back(e);
      got_q.push_back(observe(e.kind, e.port));
    end
  endtask

  task automatic idle();
    wr_en = '0; wr_clr = '0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
  endtask

  task automatic set_rd(input logic [4:0] a_0, input logic [4:0] a_1);
    rd_addr = {a_1, a_0};
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d, input logic c);
    wr_en[p] = 1'b1;
    wr_clr[p] = c;
    wr_addr[p*5 +: 5] = a;
    wr_data[p*32 +: 32] = d;
  endtask

  task automatic iss(input logic [4:0] a);
    iss_en = 1'b1;
    iss_addr = a;
  endtask

  task automatic test_reset();
    exp_t e; logic [31:0] g;
    idle();
    #1 rst = 1'b1;
    @(negedge clk); set_rd(5, 0);
    expect_v(K_DATA, 0, 0); expect_v(K_RDY, 0, 1);
    expect_v(K_DATA, 1, 0); expect_v(K_RDY, 1, 1);
    expect_v(K_CNT, 0, 0); expect_v(K_A0, 0, 0);
    #2 capture();
    rst = 1'b0;
    // Reset arrives while a write to x7 is presented
    @(negedge clk); wr(0, 7, 32'hDEADBEEF, 1'b0); set_rd(7, 7);
    #1 rst = 1'b1;
    @(negedge clk); rst = 1'b0; idle(); set_rd(7, 0);
    expect_v(K_DATA, 0, 0); expect_v(K_RDY, 0, 1);
    #2 capture();
    @(negedge clk); set_rd(7, 7);
    expect_v(K_DATA, 0, 0); expect_v(K_CNT, 0, 0);
    #2 capture();
    while (cmp_q.size() != 0) begin
      e = cmp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
      if (g !== e.val) begin
        n_bad++;
        $display("FAIL reset %s[%0d]: got %h expected %h", kname(e.kind), e.port, g, e.val);
      end
    end
  endtask

  task automatic test_bypass();
    exp_t e; logic [31:0] g;
    @(negedge clk); idle(); wr(0, 3, 32'h12345678, 1'b0); set_rd(10, 3);
    expect_v(K_DATA, 1, 32'h12345678); expect_v(K_RDY, 1, 1);
    expect_v(K_DATA, 0, 0); expect_v(K_A0, 0, 0);
    #2 capture();
    @(negedge clk); idle(); set_rd(3, 10);
    expect_v(K_DATA, 0, 32'h12345678); expect_v(K_RDY, 0, 1); expect_v(K_A0, 0, 0);
    #2 capture();
    // a0 must not see the bypass, only the stored value after the edge
    @(negedge clk); idle(); wr(1, 10, 32'hA0A00001, 1'b0); set_rd(10, 10);
    expect_v(K_DATA, 0, 32'hA0A00001); expect_v(K_A0, 0, 0);
    #2 capture();
    @(negedge clk); idle();
    expect_v(K_A0, 0, 32'hA0A00001); expect_v(K_DATA, 1, 32'hA0A00001);
    #2 capture();
    while (cmp_q.size() != 0) begin
      e = cmp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
      if (g !== e.val) begin
        n_bad++;
        $display("FAIL bypass %s[%0d]: got %h expected %h", kname(e.kind), e.port, g, e.val);
      end
    end
  endtask

  task automatic test_multi_write();
    exp_t e; logic [31:0] g;
    @(negedge clk); idle(); wr(0, 4, 32'h1, 1'b0); wr(1, 4, 32'h2, 1'b0); set_rd(4, 4);
    expect_v(K_DATA, 0, 32'h2); expect_v(K_DATA, 1, 32'h2);
    #2 capture();
    @(negedge clk); idle(); wr(0, 0, 32'hFFFFFFFF, 1'b0); set_rd(4, 0);
    expect_v(K_DATA, 0, 32'h2); expect_v(K_DATA, 1, 0); expect_v(K_RDY, 1, 1);
    #2 capture();
    @(negedge clk); idle(); set_rd(0, 0);
    expect_v(K_DATA, 0, 0); expect_v(K_RDY, 0, 1);
    #2 capture();
    while (cmp_q.size() != 0) begin
      e = cmp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
      if (g !== e.val) begin
        n_bad++;
        $display("FAIL multi_write %s[%0d]: got %h expected %h", kname(e.kind), e.port, g, e.val);
      end
    end
  endtask

  task automatic test_scoreboard();
    exp_t e; logic [31:0] g;
    @(negedge clk); idle(); iss(9); set_rd(9, 0);
    expect_v(K_RDY, 0, 1); expect_v(K_CNT, 0, 0);
    #2 capture();
    @(negedge clk); idle(); set_rd(9, 0);
    expect_v(K_RDY, 0, 0); expect_v(K_CNT, 0, 1);
    #2 capture();
    // Non-retiring write: bypassed value is ready, but the mark remains
    @(negedge clk); idle(); wr(0, 9, 32'h55, 1'b0); set_rd(9, 0);
    expect_v(K_DATA, 0, 32'h55); expect_v(K_RDY, 0, 1);
    #2 capture();
    @(negedge clk); idle(); set_rd(0, 9);
    expect_v(K_DATA, 1, 32'h55); expect_v(K_RDY, 1, 0); expect_v(K_CNT, 0, 1);
    #2 capture();
    @(negedge clk); idle(); wr(1, 9, 32'hAB, 1'b1); set_rd(9, 0);
    expect_v(K_DATA, 0, 32'hAB); expect_v(K_RDY, 0, 1);
    #2 capture();
    @(negedge clk); idle(); set_rd(9, 9);
    expect_v(K_DATA, 0, 32'hAB); expect_v(K_RDY, 0, 1); expect_v(K_CNT, 0, 0);
    #2 capture();
    while (cmp_q.size() != 0) begin
      e = cmp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
      if (g !== e.val) begin
        n_bad++;
        $display("FAIL scoreboard %s[%0d]: got %h expected %h", kname(e.kind), e.port, g, e.val);
      end
    end
  endtask

  task automatic test_set_beats_clear();
    exp_t e; logic [31:0] g;
    @(negedge clk); idle(); iss(6); wr(0, 6, 32'h66, 1'b1); set_rd(6, 0);
    expect_v(K_DATA, 0, 32'h66); expect_v(K_RDY, 0, 1);
    #2 capture();
    @(negedge clk); idle(); iss(0); set_rd(6, 0);
    expect_v(K_DATA, 0, 32'h66); expect_v(K_RDY, 0, 0);
    expect_v(K_RDY, 1, 1); expect_v(K_CNT, 0, 1);
    #2 capture();
    @(negedge clk); idle(); set_rd(0, 6);
    expect_v(K_RDY, 0, 1); expect_v(K_RDY, 1, 0); expect_v(K_CNT, 0, 1);
    #2 capture();
    @(negedge clk); idle(); wr(1, 6, 32'h77, 1'b1);
    @(negedge clk); idle(); set_rd(6, 0);
    expect_v(K_DATA, 0, 32'h77); expect_v(K_RDY, 0, 1); expect_v(K_CNT, 0, 0);
    #2 capture();
    while (cmp_q.size() != 0) begin
      e = cmp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
      if (g !== e.val) begin
        n_bad++;
        $display("FAIL set_beats_clear %s[%0d]: got %h expected %h", kname(e.kind), e.port, g, e.val);
      end
    end
  endtask

  task automatic test_flush();
    exp_t e; logic [31:0] g;
    @(negedge clk); idle(); iss(1);
    @(negedge clk); idle(); iss(1);
    expect_v(K_CNT, 0, 1);
    #2 capture();
    @(negedge clk); idle(); iss(2);
    expect_v(K_CNT, 0, 1);
    #2 capture();
    @(negedge clk); idle(); iss(10);
    expect_v(K_CNT, 0, 2);
    #2 capture();
    @(negedge clk); idle(); set_rd(1, 10);
    expect_v(K_CNT, 0, 3); expect_v(K_RDY, 0, 0); expect_v(K_RDY, 1, 0);
    #2 capture();
    // Flush squashes the same-cycle issue but lets the write through
    @(negedge clk); idle(); flush = 1'b1; iss(11); wr(0, 1, 32'h1111, 1'b0);
    @(negedge clk); idle(); set_rd(11, 2);
    expect_v(K_RDY, 0, 1); expect_v(K_RDY, 1, 1); expect_v(K_CNT, 0, 0);
    #2 capture();
    @(negedge clk); idle(); set_rd(1, 10);
    expect_v(K_RDY, 0, 1); expect_v(K_RDY, 1, 1); expect_v(K_DATA, 0, 32'h1111);
    #2 capture();
    while (cmp_q.size() != 0) begin
      e = cmp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
      if (g !== e.val) begin
        n_bad++;
        $display("FAIL flush %s[%0d]: got %h expected %h", kname(e.kind), e.port, g, e.val);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; logic [31:0] g;
    logic [4:0] a, b;
    logic [31:0] d;
    int p;
    model[0] = '0;
    for (int r = 1; r < 32; r++) begin
      @(negedge clk); idle();
      d = {r[7:0], 24'hC0FFEE} ^ (r * 32'h01010101);
      wr(r % 2, r[4:0], d, 1'b1);
      model[r] = d;
    end
    for (int n = 0; n < 24; n++) begin
      @(negedge clk); idle();
      a = 5'($urandom_range(0, 31));
      b = (n % 3 == 0) ? a : 5'($urandom_range(0, 31));
      d = $urandom;
      p = $urandom_range(0, 1);
      wr(p, a, d, 1'b1); set_rd(a, b);
      expect_v(K_DATA, 0, (a == 5'd0) ? 32'h0 : d);
      expect_v(K_DATA, 1, (b == a && a != 5'd0) ? d : model[b]);
      expect_v(K_RDY, 0, 1); expect_v(K_RDY, 1, 1);
      expect_v(K_A0, 0, model[10]);
      #2 capture();
      if (a != 5'd0) model[a] = d;
    end
    while (cmp_q.size() != 0) begin
      e = cmp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
      if (g !== e.val) begin
        n_bad++;
        $display("FAIL back_to_back %s[%0d]: got %h expected %h", kname(e.kind), e.port, g, e.val);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_multi_write();
    test_scoreboard();
    test_set_beats_clear();
    test_flush();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_reg_file_sb
`default_nettype wire
